data_block_memory: RTL

DATA_BLOCK_MEMORY -- requirements
Module: data_block_memory

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 36 +++
 rtl/data_block_memory.sv | 98 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared widths and FSM state encoding for the block data memory.
package dmem_pkg;

    localparam int unsigned LINE_W       = 128;
    localparam int unsigned BLOCK_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port line storage: synchronous write, synchronous read into a resettable output register.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // Contents are deliberately not reset so an aborted access or reset keeps the lines.
    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds until the next completed read; writes leave it alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_block_memory.sv
// Multi-cycle block data memory with a fixed access latency and busywait handshake.
// Optional access counters are enabled with the DMEM_ACCESS_COUNT_EN macro.
module data_block_memory
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY    = 5,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0]       mem_writedata,
    output logic [LINE_W-1:0]       mem_readdata,
    output logic                    mem_busywait
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
`endif
);

    localparam int unsigned CNT_W = 4;

    dmem_state_e           state;
    logic [CNT_W-1:0]      countdown;
    logic [DEPTH_LOG2-1:0] cap_addr;
    logic [LINE_W-1:0]     cap_data;
    logic                  cap_write;
    logic                  access_fire;
    logic                  unused_addr_hi;

    // Upper block-address bits alias onto the array.
    assign unused_addr_hi = ^mem_address[BLOCK_ADDR_W-1:DEPTH_LOG2];

    assign access_fire  = (state == BUSY) && (countdown == '0);
    assign mem_busywait = (state == BUSY) || ((state == IDLE) && (mem_read || mem_write));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            countdown <= '0;
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        cap_addr  <= mem_address[DEPTH_LOG2-1:0];
                        cap_data  <= mem_writedata;
                        cap_write <= mem_write;
                        countdown <= CNT_W'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (countdown != '0) begin
                        countdown <= countdown - CNT_W'(1);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .en    (access_fire),
        .we    (cap_write),
        .addr  (cap_addr),
        .wdata (cap_data),
        .rdata (mem_readdata)
    );

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (access_fire) begin
            if (cap_write) begin
                wr_count <= wr_count + 32'(1);
            end else begin
                rd_count <= rd_count + 32'(1);
            end
        end
    end
`endif

endmodule
